pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Pipelined main decoder for the 5-stage MIPS core. Decodes the ID-stage opcode and
//  registers the control bundle through the ID/EX, EX/MEM and MEM/WB control registers.
//  Detects load-use hazards, inserts bubbles and holds PC and IF/ID while it does so.
//  Accepts a flush from branch/jump resolution. Adds an optional extended ISA.
// PARAMETERS
//  OP_W           6  opcode width
//  RA_W           5  register-address width
//  EXT_ISA        1  1: decode bne/addi/andi/ori/slti/jal; 0: these opcodes are illegal
//  LOAD_STALL_CYC 1  bubbles inserted per load-use hazard (legal range 1..3)
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     asynchronous, active-high reset
//  id_valid       in   1     ID stage holds a valid instruction
//  id_opcode      in   OP_W  opcode of the ID-stage instruction
//  id_rs, id_rt   in   RA_W  source register fields of the ID-stage instruction
//  flush          in   1     branch/jump taken; kill younger instructions
//  stall_pc       out  1     combinational; hold PC and IF/ID this cycle
//  ex_regdst      out  2     00 rt, 01 rd, 10 $31
//  ex_alusrc      out  1     ALU B operand = sign-extended immediate
//  ex_aluop       out  3     000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
//  ex_ill_op      out  1     instruction now in EX had an illegal opcode
//  mem_memread, mem_memwrite, mem_branch, mem_branch_ne, mem_jump  out 1 each
//  wb_regwrite    out  1     register-file write enable
//  wb_memtoreg    out  2     00 ALU result, 01 load data, 10 PC+4
// BEHAVIOUR
//  Reset: every registered control, the internal ID/EX rt copy, state and counter go to 0.
//   State goes to RUN. stall_pc=0.
//  Decode table (all other fields 0):
//   000000 R:    regdst=01, aluop=010, regwrite.
//   100011 lw:   alusrc, memread, regwrite, memtoreg=01.
//   101011 sw:   alusrc, memwrite.
//   000100 beq:  branch, aluop=001.
//   000010 j:    jump.
//   EXT_ISA=1 only:
//    000101 bne:  branch_ne, aluop=001.
//    001000 addi: alusrc, regwrite.
//    001100 andi: alusrc, regwrite, aluop=011.
//    001101 ori:  alusrc, regwrite, aluop=100.
//    001010 slti: alusrc, regwrite, aluop=101.
//    000011 jal:  jump, regwrite, regdst=10, memtoreg=10.
//   Any other opcode: all controls 0, ill_op=1.
//  Latency: instruction decoded in ID at cycle N has its ex_* outputs valid in N+1,
//   mem_* in N+2 and wb_* in N+3. Each stage register advances every cycle.
//  Bubble: all-zero controls with ill_op=0. Loaded into ID/EX when id_valid=0,
//   during a stall, or on flush.
//  Hazard: in RUN, a hazard exists when all of the following hold:
//   id_valid, ID/EX memread=1, ID/EX rt!=0, and ID/EX rt equals id_rs or id_rt.
//  FSM RUN/STALL, with a 2-bit counter cnt.
//   RUN + hazard: stall_pc=1, bubble into ID/EX, cnt<=LOAD_STALL_CYC-1.
//    If LOAD_STALL_CYC>1, go to STALL; otherwise stay in RUN.
//   STALL: stall_pc=1, bubble into ID/EX. If cnt==1, go to RUN; else cnt<=cnt-1.
//   A bubble in ID/EX never re-triggers the hazard, so RUN after a stall issues ID.
//  Flush has priority over everything. It is combinational for stall_pc and
//   registered for the stages.
//   stall_pc=0 while flush=1. At the edge: ID/EX and EX/MEM become bubbles, the FSM
//   goes to RUN, cnt=0. MEM/WB still captures the old EX/MEM contents.
//  Asserting reset mid-stall or mid-flush returns to the reset state immediately.
// TESTING
//  1. Stream R, lw, sw, beq, j with no hazards. Each decoded bundle must appear on ex_*
//     1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later.
//     Example: lw gives ex_alusrc=1, then mem_memread=1, then wb_memtoreg=01.
//  2. lw $5, then add using rs=5, LOAD_STALL_CYC=1: stall_pc=1 for 1 cycle, ex_* all-zero
//     for 1 cycle, then add's controls on ex_* (ex_regdst=01, ex_aluop=010).
//  3. Same sequence, LOAD_STALL_CYC=3: stall_pc=1 for exactly 3 cycles, 3 bubbles.
//     Also repeat with rt=0: no stall.
//  4. flush in the 2nd stall cycle of case 3: stall_pc=0 that cycle, ID/EX and EX/MEM
//     are bubbles next cycle, FSM returns to RUN.
//  5. EXT_ISA=1, jal: ex_regdst=10 and mem_jump=1; 2 cycles later wb_regwrite=1 and
//     wb_memtoreg=10. EXT_ISA=0, jal: all controls 0 and ex_ill_op=1.
//  6. Assert reset mid-stall: all outputs 0 asynchronously; after release, RUN with no
//     residual stall.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Main decoder for the 5-stage core; pipes the control bundle through ID/EX, EX/MEM and MEM/WB.
// Latency: ex_* valid 1 cycle after decode, mem_* 2 cycles, wb_* 3 cycles.
// Backpressure: none downstream; load-use hazards hold PC and IF/ID via stall_pc and insert bubbles.
//
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-high reset
//   id_valid, id_opcode             ID-stage instruction valid flag and opcode
//   id_rs, id_rt                    ID-stage source register fields
//   flush                           taken branch/jump; kill younger instructions
//   stall_pc                        combinational hold for PC and IF/ID
//   ex_*, mem_*, wb_*               registered control bundle per stage
module pipelined_control_unit #(
  parameter int OP_W           = 6,
  parameter int RA_W           = 5,
  parameter int EXT_ISA        = 1,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [OP_W-1:0] id_opcode,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            flush,
  output logic            stall_pc,
  output logic [1:0]      ex_regdst,
  output logic            ex_alusrc,
  output logic [2:0]      ex_aluop,
  output logic            ex_ill_op,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic            mem_branch,
  output logic            mem_branch_ne,
  output logic            mem_jump,
  output logic            wb_regwrite,
  output logic [1:0]      wb_memtoreg
);

  typedef struct packed {
    logic [1:0] regdst;
    logic       alusrc;
    logic [2:0] aluop;
    logic       ill_op;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       regwrite;
    logic [1:0] memtoreg;
  } ctrl_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);

  localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL_CYC - 1);
  localparam bit         EXT_ON   = (EXT_ISA != 0);

  ctrl_t           dec;
  ctrl_t           idex;
  ctrl_t           idex_d;
  ctrl_t           exmem;
  ctrl_t           memwb;
  logic [RA_W-1:0] idex_rt;
  logic [RA_W-1:0] idex_rt_d;
  state_t          state;
  state_t          state_d;
  logic [1:0]      cnt;
  logic [1:0]      cnt_d;
  logic            hazard;

  // Opcode decode; extended opcodes fall through to illegal when EXT_ISA=0.
  always_comb begin
    dec = '0;
    case (id_opcode)
      OP_R: begin
        dec.regdst   = 2'b01;
        dec.aluop    = 3'b010;
        dec.regwrite = 1'b1;
      end
      OP_LW: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 2'b01;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = 3'b001;
      end
      OP_J: dec.jump = 1'b1;
      OP_BNE: begin
        dec.branch_ne = EXT_ON;
        dec.aluop     = EXT_ON ? 3'b001 : 3'b000;
        dec.ill_op    = !EXT_ON;
      end
      OP_ADDI: begin
        dec.alusrc   = EXT_ON;
        dec.regwrite = EXT_ON;
        dec.ill_op   = !EXT_ON;
      end
      OP_ANDI: begin
        dec.alusrc   = EXT_ON;
        dec.regwrite = EXT_ON;
        dec.aluop    = EXT_ON ? 3'b011 : 3'b000;
        dec.ill_op   = !EXT_ON;
      end
      OP_ORI: begin
        dec.alusrc   = EXT_ON;
        dec.regwrite = EXT_ON;
        dec.aluop    = EXT_ON ? 3'b100 : 3'b000;
        dec.ill_op   = !EXT_ON;
      end
      OP_SLTI: begin
        dec.alusrc   = EXT_ON;
        dec.regwrite = EXT_ON;
        dec.aluop    = EXT_ON ? 3'b101 : 3'b000;
        dec.ill_op   = !EXT_ON;
      end
      OP_JAL: begin
        dec.jump     = EXT_ON;
        dec.regwrite = EXT_ON;
        dec.regdst   = EXT_ON ? 2'b10 : 2'b00;
        dec.memtoreg = EXT_ON ? 2'b10 : 2'b00;
        dec.ill_op   = !EXT_ON;
      end
      default: dec.ill_op = 1'b1;
    endcase
  end

  // Load in EX whose destination feeds the ID instruction. A bubble in ID/EX
  // has memread=0, so the instruction held over a stall never re-triggers.
  assign hazard = (state == RUN) && id_valid && idex.memread &&
                  (idex_rt != '0) && ((idex_rt == id_rs) || (idex_rt == id_rt));

  // Flush overrides any stall request in the same cycle.
  assign stall_pc = !flush && ((state == STALL) || hazard);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    idex_d    = dec;
    idex_rt_d = id_rt;
    if (flush || stall_pc || !id_valid) begin
      idex_d    = '0;
      idex_rt_d = '0;
    end
    if (flush) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (state == STALL) begin
      if (cnt == 2'd1) begin
        state_d = RUN;
      end
      cnt_d = cnt - 2'd1;
    end else if (hazard) begin
      cnt_d   = CNT_INIT;
      state_d = (LOAD_STALL_CYC > 1) ? STALL : RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= 2'd0;
      idex    <= '0;
      idex_rt <= '0;
      exmem   <= '0;
      memwb   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idex    <= idex_d;
      idex_rt <= idex_rt_d;
      exmem   <= flush ? '0 : idex;
      memwb   <= exmem;
    end
  end

  assign ex_regdst     = idex.regdst;
  assign ex_alusrc     = idex.alusrc;
  assign ex_aluop      = idex.aluop;
  assign ex_ill_op     = idex.ill_op;
  assign mem_memread   = exmem.memread;
  assign mem_memwrite  = exmem.memwrite;
  assign mem_branch    = exmem.branch;
  assign mem_branch_ne = exmem.branch_ne;
  assign mem_jump      = exmem.jump;
  assign wb_regwrite   = memwb.regwrite;
  assign wb_memtoreg   = memwb.memtoreg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: three instances (ext/1 bubble, ext/3 bubbles, base/2 bubbles)
// share one stimulus stream and are each compared every cycle against a behavioural model.
// Directed scenarios add literal expectations; a randomized phase follows.
module tb_pipelined_control_unit;

  typedef struct packed {
    logic [1:0] regdst;
    logic       alusrc;
    logic [2:0] aluop;
    logic       ill;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       regwrite;
    logic [1:0] memtoreg;
  } cb_t;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, J_OP = 6'b000010, JAL = 6'b000011;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       flush;

  logic [2:0][14:0] dout;
  logic [2:0]       st;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_control_unit #(
      .OP_W(6), .RA_W(5),
      .EXT_ISA((g == 2) ? 0 : 1),
      .LOAD_STALL_CYC((g == 0) ? 1 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .stall_pc(st[g]),
      .ex_regdst(dout[g][14:13]), .ex_alusrc(dout[g][12]), .ex_aluop(dout[g][11:9]),
      .ex_ill_op(dout[g][8]), .mem_memread(dout[g][7]), .mem_memwrite(dout[g][6]),
      .mem_branch(dout[g][5]), .mem_branch_ne(dout[g][4]), .mem_jump(dout[g][3]),
      .wb_regwrite(dout[g][2]), .wb_memtoreg(dout[g][1:0])
    );
  end

  int lsc_of [3] = '{1, 3, 2};
  bit ext_of [3] = '{1'b1, 1'b1, 1'b0};

  // Model: what each stage holds, the rt of the EX instruction, and bubbles still owed.
  cb_t        m_ex [3], m_mem [3], m_wb [3], m_issue [3];
  logic [4:0] m_exrt [3], m_issrt [3];
  int         m_owed [3], m_owed_n [3];
  bit         m_stall [3];

  int n_total = 0;
  int n_pass  = 0;

  logic [5:0] op_pool [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                               6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                               6'b000011};

  function automatic cb_t decode(bit ext, logic [5:0] op);
    cb_t c = '0;
    case (op)
      6'b000000: begin c.regdst = 2'b01; c.aluop = 3'b010; c.regwrite = 1; end
      6'b100011: begin c.alusrc = 1; c.memread = 1; c.regwrite = 1; c.memtoreg = 2'b01; end
      6'b101011: begin c.alusrc = 1; c.memwrite = 1; end
      6'b000100: begin c.branch = 1; c.aluop = 3'b001; end
      6'b000010: c.jump = 1;
      6'b000101: if (ext) begin c.bne = 1; c.aluop = 3'b001; end else c.ill = 1;
      6'b001000: if (ext) begin c.alusrc = 1; c.regwrite = 1; end else c.ill = 1;
      6'b001100: if (ext) begin c.alusrc = 1; c.regwrite = 1; c.aluop = 3'b011; end else c.ill = 1;
      6'b001101: if (ext) begin c.alusrc = 1; c.regwrite = 1; c.aluop = 3'b100; end else c.ill = 1;
      6'b001010: if (ext) begin c.alusrc = 1; c.regwrite = 1; c.aluop = 3'b101; end else c.ill = 1;
      6'b000011: if (ext) begin c.jump = 1; c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
                 else c.ill = 1;
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      m_exrt[k] = '0; m_owed[k] = 0;
    end
  endtask

  // Decide, from the current inputs, whether each instance stalls and what enters EX.
  task automatic model_comb();
    for (int k = 0; k < 3; k++) begin
      m_issue[k] = '0; m_issrt[k] = '0; m_stall[k] = 0; m_owed_n[k] = 0;
      if (flush) begin
        m_owed_n[k] = 0;
      end else if (m_owed[k] > 0) begin
        m_stall[k] = 1; m_owed_n[k] = m_owed[k] - 1;
      end else if (id_valid && m_ex[k].memread && m_exrt[k] != 0 &&
                   (m_exrt[k] == id_rs || m_exrt[k] == id_rt)) begin
        m_stall[k] = 1; m_owed_n[k] = lsc_of[k] - 1;
      end else if (id_valid) begin
        m_issue[k] = decode(ext_of[k], id_opcode); m_issrt[k] = id_rt;
      end
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < 3; k++) begin
      m_wb[k]   = m_mem[k];
      m_mem[k]  = flush ? '0 : m_ex[k];
      m_ex[k]   = m_issue[k];
      m_exrt[k] = m_issrt[k];
      m_owed[k] = m_owed_n[k];
    end
  endtask

  // Called at a falling edge: drive inputs, let them settle, compare everything.
  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic fl);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; flush = fl;
    #1;
    model_comb();
    for (int k = 0; k < 3; k++) begin
      cb_t e, m, w;
      e = m_ex[k]; m = m_mem[k]; w = m_wb[k];
      chk($sformatf("d%0d_stall_pc", k), 32'(st[k]), 32'(m_stall[k]));
      chk($sformatf("d%0d_ex", k), 32'(dout[k][14:8]), 32'(e[14:8]));
      chk($sformatf("d%0d_mem", k), 32'(dout[k][7:3]), 32'(m[7:3]));
      chk($sformatf("d%0d_wb", k), 32'(dout[k][2:0]), 32'(w[2:0]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic reset_mid();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_async_rst_stall", k), 32'(st[k]), 32'd0);
      chk($sformatf("d%0d_async_rst_outs", k), 32'(dout[k]), 32'd0);
    end
    model_reset();
    id_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_reset_stall", k), 32'(st[k]), 32'd0);
      chk($sformatf("d%0d_reset_outs", k), 32'(dout[k]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Hazard-free stream R, lw, sw, beq, j.
    step(1, R_OP, 1, 2, 0); advance();
    step(1, LW, 1, 5, 0);   chk("t1_R_ex_regdst", 32'(dout[0][14:13]), 32'd1); advance();
    step(1, SW, 3, 4, 0);   chk("t1_lw_ex_alusrc", 32'(dout[0][12]), 32'd1); advance();
    step(1, BEQ, 6, 7, 0);  chk("t1_lw_mem_memread", 32'(dout[0][7]), 32'd1);
                            chk("t1_R_wb_regwrite", 32'(dout[0][2]), 32'd1); advance();
    step(1, J_OP, 0, 0, 0); chk("t1_lw_wb_memtoreg", 32'(dout[0][1:0]), 32'd1);
                            chk("t1_beq_ex_aluop", 32'(dout[0][11:9]), 32'd1); advance();
    step(0, R_OP, 0, 0, 0); chk("t1_beq_mem_branch", 32'(dout[0][5]), 32'd1); advance();
    step(0, R_OP, 0, 0, 0); chk("t1_j_mem_jump", 32'(dout[0][3]), 32'd1); advance();

    // lw $5 then R using rs=5: 1, 3 and 2 bubbles for the three instances.
    step(1, LW, 1, 5, 0); advance();
    step(1, R_OP, 5, 2, 0); chk("t2_d0_stall", 32'(st[0]), 32'd1);
                            chk("t3_d1_stall1", 32'(st[1]), 32'd1); advance();
    step(1, R_OP, 5, 2, 0); chk("t2_d0_stall_end", 32'(st[0]), 32'd0);
                            chk("t2_d0_ex_bubble", 32'(dout[0][14:8]), 32'd0);
                            chk("t3_d1_stall2", 32'(st[1]), 32'd1);
                            chk("t2_d0_lw_mem", 32'(dout[0][7]), 32'd1); advance();
    step(1, R_OP, 5, 2, 0); chk("t2_d0_ex_regdst", 32'(dout[0][14:13]), 32'd1);
                            chk("t2_d0_ex_aluop", 32'(dout[0][11:9]), 32'd2);
                            chk("t3_d1_stall3", 32'(st[1]), 32'd1); advance();
    step(1, R_OP, 5, 2, 0); chk("t3_d1_stall_end", 32'(st[1]), 32'd0);
                            chk("t3_d1_ex_bubble", 32'(dout[1][14:8]), 32'd0); advance();
    step(0, R_OP, 0, 0, 0); chk("t3_d1_ex_regdst", 32'(dout[1][14:13]), 32'd1); advance();

    // Load to $0 never stalls.
    step(1, LW, 1, 0, 0); advance();
    step(1, R_OP, 0, 0, 0); chk("t3_rt0_d1_nostall", 32'(st[1]), 32'd0);
                            chk("t3_rt0_d0_nostall", 32'(st[0]), 32'd0); advance();
    step(0, R_OP, 0, 0, 0); advance();

    // Flush during the second stall cycle of the 3-bubble instance.
    step(1, LW, 1, 7, 0); advance();
    step(1, R_OP, 7, 2, 0); chk("t4_d1_stall", 32'(st[1]), 32'd1); advance();
    step(1, R_OP, 7, 2, 1); chk("t4_flush_stall_low", 32'(st[1]), 32'd0); advance();
    step(1, R_OP, 7, 2, 0); chk("t4_run_no_stall", 32'(st[1]), 32'd0);
                            chk("t4_ex_bubble", 32'(dout[1][14:8]), 32'd0);
                            chk("t4_mem_bubble", 32'(dout[1][7:3]), 32'd0);
                            chk("t4_wb_keeps_lw", 32'(dout[1][1:0]), 32'd1); advance();
    step(0, R_OP, 0, 0, 0); chk("t4_R_issued", 32'(dout[1][14:13]), 32'd1); advance();

    // jal with and without the extended ISA.
    step(1, JAL, 1, 2, 0); advance();
    step(0, R_OP, 0, 0, 0); chk("t5_jal_ex_regdst", 32'(dout[0][14:13]), 32'd2);
                            chk("t5_base_jal_ill", 32'(dout[2][14:8]), 32'd1); advance();
    step(0, R_OP, 0, 0, 0); chk("t5_jal_mem_jump", 32'(dout[0][3]), 32'd1);
                            chk("t5_base_jal_mem", 32'(dout[2][7:3]), 32'd0); advance();
    step(0, R_OP, 0, 0, 0); chk("t5_jal_wb", 32'(dout[0][2:0]), 32'b110);
                            chk("t5_base_jal_wb", 32'(dout[2][2:0]), 32'd0); advance();

    // Flush kills the lw sitting in EX.
    step(1, LW, 1, 9, 0); advance();
    step(1, SW, 3, 4, 1); chk("fl_lw_in_ex", 32'(dout[0][12]), 32'd1); advance();
    step(0, R_OP, 0, 0, 0); chk("fl_mem_killed", 32'(dout[0][7:3]), 32'd0);
                            chk("fl_ex_killed", 32'(dout[0][14:8]), 32'd0); advance();
    step(0, R_OP, 0, 0, 0); chk("fl_wb_killed", 32'(dout[0][2:0]), 32'd0); advance();

    // Reset in the middle of a stall.
    step(1, LW, 1, 3, 0); advance();
    step(1, R_OP, 3, 2, 0); chk("t6_d1_stall", 32'(st[1]), 32'd1); advance();
    step(1, R_OP, 3, 2, 0);
    reset_mid();
    step(1, R_OP, 3, 2, 0); chk("t6_d1_no_residual", 32'(st[1]), 32'd0);
                            chk("t6_d0_no_residual", 32'(st[0]), 32'd0); advance();
    step(0, R_OP, 0, 0, 0); chk("t6_R_issued", 32'(dout[1][14:13]), 32'd1); advance();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 15) < 11) op = op_pool[$urandom_range(0, 10)];
      else op = 6'($urandom);
      step(($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 399) == 0) reset_mid();
      else advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
